// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction memory request/grant and response bundle
interface fetch_queue_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - prefetching fetch stage with a DEPTH-entry instruction queue (optional FETCH_BYPASS_EN)
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                stage_clk,
  input  logic                reset_n,
  fetch_queue_unit_if.master  imem,
  input  logic                take_new_pc,
  input  logic [XLEN-1:0]     pc_new,
  input  logic                stage_ena,
  input  logic                stage_x,
  output logic [31:0]         instr,
  output logic [XLEN-1:0]     pc_dec,
  output logic                instr_valid,
  output logic [XLEN-1:0]     fetch_pc
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];

  logic [CW:0]     credit_used;
  logic [CW-1:0]   outstanding_nxt;
  logic            grant;
  logic            rsp_take;
  logic            rsp_drop;
  logic            rsp_good;
  logic            out_bubble;
  logic            bypass;
  logic            push;
  logic            pop;

  assign imem.imem_addr = fetch_pc;

  // Request credit, response classification and queue push/pop decisions
  always_comb begin
    credit_used   = {1'b0, count} + {1'b0, outstanding};
    imem.imem_req = reset_n && (credit_used < {1'b0, DEPTH_C});
    grant         = imem.imem_req && imem.imem_gnt;
    // A response with nothing outstanding is a leftover from before a reset
    rsp_take      = imem.imem_rvalid && (outstanding != '0);
    rsp_drop      = rsp_take && (drop_cnt != '0);
    rsp_good      = rsp_take && (drop_cnt == '0);
    outstanding_nxt = outstanding;
    if (grant)    outstanding_nxt = outstanding_nxt + CW'(1);
    if (rsp_take) outstanding_nxt = outstanding_nxt - CW'(1);
    out_bubble    = stage_x || take_new_pc;
`ifdef FETCH_BYPASS_EN
    bypass        = rsp_good && (count == '0) && stage_ena && !out_bubble;
`else
    bypass        = 1'b0;
`endif
    pop           = !out_bubble && stage_ena && (count != '0);
    push          = rsp_good && !take_new_pc && !bypass;
  end

  // Fetch/response PCs, credit counters and queue pointers; redirect flushes
  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (take_new_pc) begin
        // Everything still in flight, including this cycle's grant, is stale
        fetch_pc <= pc_new;
        resp_pc  <= pc_new;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (grant)    fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_good) resp_pc  <= resp_pc + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (push)     wr_ptr   <= wr_ptr + AW'(1);
        if (pop)      rd_ptr   <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage; entries are only read while count says they are valid
  always_ff @(posedge stage_clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= imem.imem_rdata;
    end
  end

  // Decode-facing output register: bubble on stage_x/redirect, hold when not enabled
  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) begin
      instr       <= '0;
      pc_dec      <= '0;
      instr_valid <= 1'b0;
    end else if (out_bubble) begin
      instr       <= '0;
      pc_dec      <= '0;
      instr_valid <= 1'b0;
    end else if (stage_ena) begin
      if (bypass) begin
        instr       <= imem.imem_rdata;
        pc_dec      <= resp_pc;
        instr_valid <= 1'b1;
      end else if (count != '0) begin
        instr       <= q_instr[rd_ptr];
        pc_dec      <= q_pc[rd_ptr];
        instr_valid <= 1'b1;
      end else begin
        instr       <= '0;
        pc_dec      <= '0;
        instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        stage_clk   = 1'b0;
  logic        reset_n     = 1'b0;
  logic        take_new_pc = 1'b0;
  logic [31:0] pc_new      = '0;
  logic        stage_ena   = 1'b0;
  logic        stage_x     = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_dec;
  logic        instr_valid;
  logic [31:0] fetch_pc;

  fetch_queue_unit_if #(.XLEN(XLEN)) imem ();

  fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .stage_clk  (stage_clk),
    .reset_n    (reset_n),
    .imem       (imem),
    .take_new_pc(take_new_pc),
    .pc_new     (pc_new),
    .stage_ena  (stage_ena),
    .stage_x    (stage_x),
    .instr      (instr),
    .pc_dec     (pc_dec),
    .instr_valid(instr_valid),
    .fetch_pc   (fetch_pc)
  );

  always #5 stage_clk = ~stage_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  logic [31:0] m_fetch_pc, m_resp_pc;
  logic [63:0] m_q[$];
  int          m_out, m_drop;
  logic [31:0] m_instr, m_pc_dec;
  logic        m_valid;
  logic        obs_req, exp_req, last_grant;
  logic [31:0] obs_addr, exp_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_fetch_pc = RESET_PC; m_resp_pc = RESET_PC;
    m_q.delete(); m_out = 0; m_drop = 0;
    m_instr = '0; m_pc_dec = '0; m_valid = 1'b0;
    mem_addr_q.delete(); mem_due_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stage_ena = 0; stage_x = 0; take_new_pc = 0;
    imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = '0;
    repeat (2) @(posedge stage_clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  // Drive one cycle, memory answers in order after mem_lat cycles, model follows the stage rules
  task automatic tick(input logic ena, input logic x, input logic tnp, input logic [31:0] pcn, input logic gnt);
    logic        rv, good, byp, req;
    logic [31:0] rd, gaddr;
    logic [63:0] e;
    stage_ena = ena; stage_x = x; take_new_pc = tnp; pc_new = pcn; imem.imem_gnt = gnt;
    rv = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
    rd = rv ? mem_word(mem_addr_q[0]) : 32'hDEAD_BEEF;
    imem.imem_rvalid = rv; imem.imem_rdata = rd;
    #1;
    req = (m_q.size() + m_out) < DEPTH;
    obs_req = imem.imem_req; obs_addr = imem.imem_addr;
    exp_req = req; exp_addr = m_fetch_pc;
    last_grant = req && gnt;
    gaddr = m_fetch_pc;
    good = 1'b0;
    if (rv && m_out > 0) begin
      if (m_drop > 0) m_drop--; else good = 1'b1;
      m_out--;
    end
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (last_grant) begin
      m_out++; m_fetch_pc += 32'd4;
      mem_addr_q.push_back(gaddr); mem_due_q.push_back(cyc + mem_lat);
    end
    byp = 1'b0;
    if (x || tnp) begin
      m_instr = '0; m_pc_dec = '0; m_valid = 1'b0;
    end else if (ena) begin
`ifdef FETCH_BYPASS_EN
      if (good && m_q.size() == 0) begin
        byp = 1'b1; m_instr = rd; m_pc_dec = m_resp_pc; m_valid = 1'b1;
      end else
`endif
      if (m_q.size() > 0) begin
        e = m_q.pop_front(); m_pc_dec = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1;
      end else begin
        m_instr = '0; m_pc_dec = '0; m_valid = 1'b0;
      end
    end
    if (good && !tnp && !byp) m_q.push_back({m_resp_pc, rd});
    if (good) m_resp_pc += 32'd4;
    if (tnp) begin
      m_q.delete(); m_fetch_pc = pcn; m_resp_pc = pcn; m_drop = m_out;
    end
    @(posedge stage_clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    repeat (5) tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want %h", instr, 32'h0); end
    n_checks++; if (pc_dec !== 32'h0) begin n_fail++; $display("FAIL reset_pc_dec got %h want %h", pc_dec, 32'h0); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem.imem_req); end
    n_checks++; if (fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_fetch_pc got %h want %h", fetch_pc, RESET_PC); end
    do_reset();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic        seen;
    do_reset(); mem_lat = 1; exp_pc = RESET_PC; seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
        n_fail++; $display("FAIL stream_req cyc %0d got %b/%h want %b/%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
      end
      n_checks++;
      if ({instr_valid, pc_dec, instr, fetch_pc} !== {m_valid, m_pc_dec, m_instr, m_fetch_pc}) begin
        n_fail++; $display("FAIL stream_out cyc %0d got %b/%h/%h want %b/%h/%h", cyc, instr_valid, pc_dec, instr, m_valid, m_pc_dec, m_instr);
      end
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (pc_dec !== exp_pc || instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL stream_seq got %h/%h want %h/%h", pc_dec, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4; seen = 1'b1;
      end else if (seen) begin
        n_checks++; n_fail++; $display("FAIL stream_gap cyc %0d got valid 0 want 1", cyc);
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stream_none got no delivery want some"); end
  endtask

  task automatic test_stall();
    int grants;
    int found;
    do_reset(); mem_lat = 1; grants = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
      if (obs_req) grants++;
    end
    n_checks++; if (grants != DEPTH) begin n_fail++; $display("FAIL stall_grants got %0d want %0d", grants, DEPTH); end
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_low got %b want 0", obs_req); end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (instr_valid !== 1'b1 || pc_dec !== 32'(i * 4) || instr !== mem_word(32'(i * 4))) begin
        n_fail++; $display("FAIL stall_drain %0d got %b/%h/%h want 1/%h/%h", i, instr_valid, pc_dec, instr, 32'(i * 4), mem_word(32'(i * 4)));
      end
    end
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      if (instr_valid === 1'b1) found = 1;
    end
    n_checks++;
    if (found == 0 || pc_dec !== 32'h10) begin
      n_fail++; $display("FAIL stall_resume got %0d/%h want 1/%h", found, pc_dec, 32'h10);
    end
  endtask

  task automatic test_redirect();
    int found;
    do_reset(); mem_lat = 3;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL redirect_bubble got %b/%h want 0/0", instr_valid, instr); end
    n_checks++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL redirect_fetch_pc got %h want %h", fetch_pc, 32'h100); end
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      if (instr_valid === 1'b1) found = 1;
    end
    n_checks++;
    if (found == 0 || pc_dec !== 32'h100 || instr !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL redirect_target got %0d/%h/%h want 1/%h/%h", found, pc_dec, instr, 32'h100, mem_word(32'h100));
    end
  endtask

  task automatic test_stage_x();
    do_reset(); mem_lat = 1;
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if ({instr_valid, instr} !== 33'h0) begin n_fail++; $display("FAIL stagex_bubble got %b/%h want 0/0", instr_valid, instr); end
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (instr_valid !== 1'b1 || pc_dec !== 32'h0 || instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL stagex_head got %b/%h/%h want 1/0/%h", instr_valid, pc_dec, instr, mem_word(32'h0)); end
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (instr_valid !== 1'b1 || pc_dec !== 32'h4) begin n_fail++; $display("FAIL stagex_next got %b/%h want 1/4", instr_valid, pc_dec); end
  endtask

  task automatic test_gnt_hold();
    logic [31:0] hold;
    hold = m_fetch_pc;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
      n_checks++;
      if (obs_req !== 1'b1 || obs_addr !== hold || fetch_pc !== hold) begin
        n_fail++; $display("FAIL gnt_hold %0d got %b/%h/%h want 1/%h/%h", i, obs_req, obs_addr, fetch_pc, hold, hold);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pcn;
    for (int lat = 1; lat <= 3; lat++) begin
      do_reset(); mem_lat = lat;
      for (int i = 0; i < 200; i++) begin
        if (lat == 2 && i == 100) do_reset();
        pcn = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 24) == 0, pcn, $urandom_range(0, 9) < 7);
        n_checks++;
        if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
          n_fail++; $display("FAIL random_req cyc %0d got %b/%h want %b/%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
        end
        n_checks++;
        if ({instr_valid, pc_dec, instr, fetch_pc} !== {m_valid, m_pc_dec, m_instr, m_fetch_pc}) begin
          n_fail++; $display("FAIL random_out cyc %0d got %b/%h/%h/%h want %b/%h/%h/%h", cyc, instr_valid, pc_dec, instr, fetch_pc, m_valid, m_pc_dec, m_instr, m_fetch_pc);
        end
      end
    end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    do_reset(); mem_lat = 1;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0013 || pc_dec !== 32'h0) begin
      n_fail++; $display("FAIL bypass got %b/%h/%h want 1/00000013/0", instr_valid, instr, pc_dec);
    end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_stage_x();
    test_gnt_hold();
    test_random();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction fetch stage with a prefetch queue. It issues word requests to instruction memory over a request/grant and response handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It delivers one instruction per enabled cycle to decode, and supports PC redirects, which flush the queue and discard in-flight responses. It sits between instruction memory and the decode stage, in place of the single-register fetch stage.

## Interface
- XLEN, 32, address/PC width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- stage_clk  in  1  stage clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address, equals fetch_pc
- imem_gnt  in  1  request accepted this cycle; only meaningful with imem_req
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after grant
- imem_rdata  in  32  response instruction word
- take_new_pc  in  1  redirect: jump or misprediction
- pc_new  in  XLEN  redirect target
- stage_ena  in  1  decode accepts a new instruction this cycle
- stage_x  in  1  insert a bubble into the output register
- instr  out  32  instruction to decode
- pc_dec  out  XLEN  PC of instr
- instr_valid  out  1  instr/pc_dec hold a real instruction
- fetch_pc  out  XLEN  next address to request

## Operation
- State:
  - fetch_pc
  - resp_pc (PC of the next expected response)
  - queue entries {pc, instr}, with count
  - outstanding (granted, not yet returned)
  - drop_cnt (responses to discard)
  - Counter widths: clog2(DEPTH)+1.
- Request: imem_req = reset_n && (count + outstanding < DEPTH). Pops in the same cycle earn no credit.
- Grant (imem_req && imem_gnt): fetch_pc += 4, outstanding += 1.
- Response with outstanding = 0: ignored.
- Response with drop_cnt > 0: discarded; drop_cnt -= 1 and outstanding -= 1.
- Any other response: push {resp_pc, imem_rdata}; resp_pc += 4; outstanding -= 1.
- Redirect (take_new_pc = 1):
  - fetch_pc and resp_pc load pc_new.
  - Queue cleared (count = 0).
  - drop_cnt loads outstanding as updated by this cycle's grant and response. A same-cycle grant at the old address is therefore dropped.
  - A same-cycle response is consumed under the old rules and not queued.
- Output register priority: reset_n low > stage_x > take_new_pc > stage_ena.
  - stage_x: instr = 0, pc_dec = 0, instr_valid = 0; queue is not popped.
  - take_new_pc: same bubble as stage_x.
  - stage_ena with count > 0: pop head into pc_dec/instr; instr_valid = 1.
  - stage_ena with queue empty: bubble.
  - stage_ena = 0: hold all outputs.
- Push and pop in the same cycle are allowed; count is unchanged.
- PC arithmetic is modulo 2^XLEN; wrap-around is silent.

## Timing
- Reset values:
  - instr = 0, pc_dec = 0, instr_valid = 0
  - fetch_pc = resp_pc = RESET_PC
  - count = outstanding = drop_cnt = 0
  - imem_req = 0 while reset_n is low
- Reset mid-operation clears all state. Memory is reset with the block, so late responses hit outstanding = 0 and are ignored.
- imem_req and imem_addr are combinational from registers and do not depend on imem_gnt. The request holds with a stable address until granted.
- Latency, default build: rvalid at edge t is queued at t; with stage_ena, instr_valid rises at edge t+1.
- Throughput: one instruction per cycle when memory sustains one grant and one response per cycle and DEPTH ≥ round-trip cycles + 1.
- The queue never overflows; this follows from the request credit rule.

## Configuration
- FETCH_BYPASS_EN defined: bypass path enabled. When count = 0, the response is not dropped, stage_ena = 1, stage_x = 0 and take_new_pc = 0, the response goes straight to instr/pc_dec at edge t without being pushed. Latency from rvalid to output is 0 edges.
- Undefined: every response passes through the queue, with the default latency above.

## Test plan
- Reset release, 1-cycle memory, gnt always 1, stage_ena = 1: pc_dec sequence 0x0, 0x4, 0x8…, instr matches memory, instr_valid continuous after first delivery.
- stage_ena = 0 for 10 cycles: exactly 4 grants accepted (DEPTH = 4), imem_req then low. On release, 4 queued instructions emerge in order on consecutive cycles, then streaming resumes at 0x10.
- 3-cycle memory, 2 outstanding, take_new_pc with pc_new = 0x100: next 2 responses discarded, instr bubble for that cycle, next valid pc_dec = 0x100.
- stage_x pulse with 2 entries queued: instr = 0, instr_valid = 0 for one cycle; the next cycle delivers the retained head PC.
- imem_gnt held 0 for 5 cycles: imem_req stays 1, imem_addr stable, fetch_pc unchanged, no output change beyond draining the queue.
- With FETCH_BYPASS_EN, empty queue, rvalid with data 0x00000013 at edge t: instr = 0x00000013 and instr_valid = 1 after edge t.
